// File: rtl/fb_mem_arbiter_pkg.sv
// Shared types and constants for the frame-buffer arbiter: FSM states,
// transaction owner and the 2-bit cell encoding packed 16 per word.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        WAIT_RD = 2'd2,
        WAIT_WR = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_SIM  = 1'b1
    } owner_t;

    localparam int CELL_W         = 2;
    localparam int CELLS_PER_WORD = 16;

    localparam logic [CELL_W-1:0] EMPTY    = 2'd0;
    localparam logic [CELL_W-1:0] SAND     = 2'd1;
    localparam logic [CELL_W-1:0] SAND_ALT = 2'd2;
    localparam logic [CELL_W-1:0] WALL     = 2'd3;

    // Extract cell idx (0 = least significant) from a packed word.
    function automatic logic [CELL_W-1:0] cell_at(input logic [CELL_W*CELLS_PER_WORD-1:0] word,
                                                  input int idx);
        return word[idx*CELL_W +: CELL_W];
    endfunction

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Avalon-MM frame-buffer master bus shared between the arbiter (master)
// and the memory slave.
interface fb_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_writeresponsevalid;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid, avm_writeresponsevalid
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_waitrequest, avm_readdata, avm_readdatavalid, avm_writeresponsevalid
    );
endinterface

// File: rtl/fb_mem_arbiter_pick.sv
// Grant decision for the frame-buffer arbiter: display wins contention
// unless the simulation requester has been passed over STARVE_MAX times.
module fb_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic arb_en,
    input  logic disp_req,
    input  logic sim_req,
    output logic grant_valid,
    output logic grant_sim
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_reg;

    always_comb begin
        grant_valid = arb_en & (disp_req | sim_req);
        grant_sim   = arb_en & sim_req & (~disp_req | (starve_cnt_reg == CNT_MAX));
    end

    // Counts display grants made over a waiting sim request; any gap in
    // sim_req or a sim grant restarts the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (arb_en) begin
            if (!sim_req || grant_sim) begin
                starve_cnt_reg <= '0;
            end else if (disp_req && starve_cnt_reg != CNT_MAX) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fb_mem_arbiter.sv
// Two-requester arbiter for the single Avalon-MM frame-buffer master, one
// transaction in flight. Define FB_ARB_STATS_EN to add grant/stall counters.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              sim_req,
    input  logic              sim_we,
    input  logic [ADDR_W-1:0] sim_addr,
    input  logic [DATA_W-1:0] sim_wdata,
    output logic              sim_ack,
    output logic              sim_rvalid,
    output logic              sim_wdone,
    output logic [DATA_W-1:0] sim_rdata,
    fb_mem_arbiter_if.master  avm,
    output logic              busy
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       disp_grants,
    output logic [15:0]       sim_grants,
    output logic [15:0]       stall_cycles
`endif
);
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_CMD     = CMD;
    localparam logic [1:0] ST_WAIT_RD = WAIT_RD;
    localparam logic [1:0] ST_WAIT_WR = WAIT_WR;

    logic [1:0]        state_reg;
    owner_t            owner_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] disp_rdata_reg;
    logic [DATA_W-1:0] sim_rdata_reg;
    logic              disp_rvalid_reg;
    logic              sim_rvalid_reg;
    logic              sim_wdone_reg;

    logic grant_valid;
    logic grant_sim;
    logic accept;

    fb_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clock       (clock),
        .reset       (reset),
        .arb_en      (state_reg == ST_IDLE),
        .disp_req    (disp_req),
        .sim_req     (sim_req),
        .grant_valid (grant_valid),
        .grant_sim   (grant_sim)
    );

    assign accept = (state_reg == ST_CMD) && !avm.avm_waitrequest;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= OWN_DISP;
            addr_reg        <= '0;
            we_reg          <= 1'b0;
            wdata_reg       <= '0;
            disp_rdata_reg  <= '0;
            sim_rdata_reg   <= '0;
            disp_rvalid_reg <= 1'b0;
            sim_rvalid_reg  <= 1'b0;
            sim_wdone_reg   <= 1'b0;
        end else begin
            disp_rvalid_reg <= 1'b0;
            sim_rvalid_reg  <= 1'b0;
            sim_wdone_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_reg <= grant_sim ? OWN_SIM : OWN_DISP;
                        addr_reg  <= grant_sim ? sim_addr : disp_addr;
                        we_reg    <= grant_sim & sim_we;
                        wdata_reg <= grant_sim ? sim_wdata : wdata_reg;
                        state_reg <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (accept) begin
                        state_reg <= we_reg ? ST_WAIT_WR : ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    // Data lands only in the owner's register; the other side keeps its last word.
                    if (avm.avm_readdatavalid) begin
                        if (owner_reg == OWN_SIM) begin
                            sim_rdata_reg  <= avm.avm_readdata;
                            sim_rvalid_reg <= 1'b1;
                        end else begin
                            disp_rdata_reg  <= avm.avm_readdata;
                            disp_rvalid_reg <= 1'b1;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                ST_WAIT_WR: begin
                    if (avm.avm_writeresponsevalid) begin
                        sim_wdone_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign avm.avm_address   = addr_reg;
    assign avm.avm_writedata = wdata_reg;
    assign avm.avm_read      = (state_reg == ST_CMD) && !we_reg;
    assign avm.avm_write     = (state_reg == ST_CMD) && we_reg;

    assign disp_ack    = accept && (owner_reg == OWN_DISP);
    assign sim_ack     = accept && (owner_reg == OWN_SIM);
    assign disp_rvalid = disp_rvalid_reg;
    assign disp_rdata  = disp_rdata_reg;
    assign sim_rvalid  = sim_rvalid_reg;
    assign sim_wdone   = sim_wdone_reg;
    assign sim_rdata   = sim_rdata_reg;
    assign busy        = (state_reg != ST_IDLE);

`ifdef FB_ARB_STATS_EN
    logic [2:0]  stat_inc;
    logic [15:0] stat_reg [3];

    assign stat_inc = {(state_reg == ST_CMD) && avm.avm_waitrequest,
                       grant_valid && grant_sim,
                       grant_valid && !grant_sim};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        always_ff @(posedge clock) begin
            if (reset) begin
                stat_reg[gi] <= '0;
            end else if (stat_inc[gi] && stat_reg[gi] != 16'hFFFF) begin
                stat_reg[gi] <= stat_reg[gi] + 16'd1;
            end
        end
    end

    assign disp_grants  = stat_reg[0];
    assign sim_grants   = stat_reg[1];
    assign stall_cycles = stat_reg[2];
`endif
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: stimulus pushes expected ack/response
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_fb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = '0;
    logic        disp_ack, disp_rvalid;
    logic [31:0] disp_rdata;
    logic        sim_req = 1'b0;
    logic        sim_we = 1'b0;
    logic [15:0] sim_addr = '0;
    logic [31:0] sim_wdata = '0;
    logic        sim_ack, sim_rvalid, sim_wdone;
    logic [31:0] sim_rdata;
    logic        busy;
`ifdef FB_ARB_STATS_EN
    logic [15:0] disp_grants, sim_grants, stall_cycles;
`endif

    fb_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) avm_if ();

    fb_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_ack    (disp_ack),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .sim_req     (sim_req),
        .sim_we      (sim_we),
        .sim_addr    (sim_addr),
        .sim_wdata   (sim_wdata),
        .sim_ack     (sim_ack),
        .sim_rvalid  (sim_rvalid),
        .sim_wdone   (sim_wdone),
        .sim_rdata   (sim_rdata),
        .avm         (avm_if),
        .busy        (busy)
`ifdef FB_ARB_STATS_EN
        ,
        .disp_grants (disp_grants),
        .sim_grants  (sim_grants),
        .stall_cycles(stall_cycles)
`endif
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Slave model: programmable stall count and read latency, write response after 1 cycle.
    logic [31:0] mem [256];
    int          stall_cfg = 0;
    int          rd_lat = 1;
    int          stall_left = 0;
    int          rd_timer = 0;
    int          wr_timer = 0;
    logic [31:0] rd_data = '0;
    logic        strobe;

    assign strobe = avm_if.avm_read | avm_if.avm_write;
    assign avm_if.avm_waitrequest        = strobe && (stall_left != 0);
    assign avm_if.avm_readdata           = rd_data;
    assign avm_if.avm_readdatavalid      = (rd_timer == 1);
    assign avm_if.avm_writeresponsevalid = (wr_timer == 1);

    always @(posedge clock) begin
        if (rd_timer != 0) rd_timer <= rd_timer - 1;
        if (wr_timer != 0) wr_timer <= wr_timer - 1;
        if (strobe) begin
            if (stall_left != 0) begin
                stall_left <= stall_left - 1;
            end else begin
                stall_left <= stall_cfg;
                if (avm_if.avm_read) begin
                    rd_data  <= mem[avm_if.avm_address[7:0]];
                    rd_timer <= rd_lat;
                end else begin
                    wr_timer <= 1;
                end
            end
        end else begin
            stall_left <= stall_cfg;
        end
    end

    // Cycles where the stalled write shows exactly the requested command fields.
    int stab_cnt = 0;
    always @(negedge clock)
        if (avm_if.avm_write && avm_if.avm_waitrequest &&
            avm_if.avm_address == 16'h0123 && avm_if.avm_writedata == 32'hFFFF0000)
            stab_cnt <= stab_cnt + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Event kinds: 0 disp_ack, 1 sim_ack, 2 disp_rvalid, 3 sim_rvalid, 4 sim_wdone.
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [31:0] other;
    } exp_t;
    exp_t  sb[$];
    string knames[5] = '{"disp_ack", "sim_ack", "disp_rvalid", "sim_rvalid", "sim_wdone"};
    int    last_cyc[5] = '{0, 0, 0, 0, 0};
    bit    mon_en = 1'b0;
    logic [31:0] exp_disp_rd = '0;
    logic [31:0] exp_sim_rd = '0;

    task automatic push(input int kind, input logic [31:0] data, input logic [31:0] other);
        exp_t e;
        e.kind = kind; e.data = data; e.other = other;
        sb.push_back(e);
    endtask

    logic [4:0] flags;
    always @(negedge clock) begin
        flags = {sim_wdone, sim_rvalid, disp_rvalid, sim_ack, disp_ack};
        if (mon_en) begin
            for (int k = 0; k < 5; k++) begin
                if (flags[k]) begin
                    last_cyc[k] = cyc;
                    if (sb.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_%s: pulse at cycle %0d, required none", knames[k], cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        n_cmp++;
                        if (e.kind != k) begin
                            n_fail++;
                            $display("FAIL order: got %s, required %s (cycle %0d)", knames[k], knames[e.kind], cyc);
                        end else begin
                            $display("txn %s ok at cycle %0d", knames[k], cyc);
                        end
                        if (k == 2) begin
                            chk("disp_rdata", disp_rdata, e.data);
                            chk("sim_rdata_hold", sim_rdata, e.other);
                        end else if (k == 3) begin
                            chk("sim_rdata", sim_rdata, e.data);
                            chk("disp_rdata_hold", disp_rdata, e.other);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ack(input bit sim, input string name, output logic [1:0] fs);
        bit got = 1'b0;
        fs = 2'b00;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clock);
            if (i == 0) fs = {avm_if.avm_read, avm_if.avm_write};
            got = sim ? sim_ack : disp_ack;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_ack_timeout: got no ack in 64 cycles, required ack", name);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clock);
        chk({name, "_pending"}, 64'(sb.size()), 64'd0);
        @(negedge clock);
    endtask

    task automatic run_txn(input string name, input bit sim, input bit we,
                           input logic [15:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int stall, input int lat,
                           output int rc, output logic [1:0] fs);
        stall_cfg = stall;
        rd_lat    = lat;
        push(sim ? 1 : 0, '0, '0);
        if (we) begin
            push(4, '0, '0);
        end else if (sim) begin
            push(3, rd, exp_disp_rd);
            exp_sim_rd = rd;
        end else begin
            push(2, rd, exp_sim_rd);
            exp_disp_rd = rd;
        end
        if (sim) begin
            sim_addr = addr; sim_we = we; sim_wdata = wd; sim_req = 1'b1;
        end else begin
            disp_addr = addr; disp_req = 1'b1;
        end
        rc = cyc;
        wait_ack(sim, name, fs);
        sim_req  = 1'b0;
        disp_req = 1'b0;
        drain(name);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_disp_rd = '0;
        exp_sim_rd  = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rc;
        int          n_ack;
        logic [1:0]  fs;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hAAAA5555;
        mem[8'h20] = 32'hDDDD0020;
        mem[8'h30] = 32'h55550030;
        mem[8'h40] = 32'h12345678;
        mem[8'h41] = 32'h0BAD0041;
        mem[8'h50] = 32'hBEEF0050;
        mem[8'h51] = 32'h0DD00051;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'({avm_if.avm_read, avm_if.avm_write}), 64'd0);
        chk("rst_address", 64'(avm_if.avm_address), 64'd0);
        chk("rst_writedata", 64'(avm_if.avm_writedata), 64'd0);
        chk("rst_pulses", 64'({disp_ack, disp_rvalid, sim_ack, sim_rvalid, sim_wdone}), 64'd0);
        chk("rst_rdata", {disp_rdata, sim_rdata}, 64'd0);
        mon_en = 1'b1;

        // Display read, no stall, latency 1: rvalid 3 cycles after req is driven.
        run_txn("disp_rd", 1'b0, 1'b0, 16'h0010, '0, 32'hAAAA5555, 0, 1, rc, fs);
        chk("disp_rd_strobe", 64'(fs), 64'd2);
        chk("disp_rd_ack_lat", 64'(last_cyc[0] - rc), 64'd1);
        chk("disp_rd_rvalid_lat", 64'(last_cyc[2] - rc), 64'd3);

        // Sim write with 3 stall cycles.
        begin
            int s0;
            s0 = stab_cnt;
            run_txn("sim_wr", 1'b1, 1'b1, 16'h0123, 32'hFFFF0000, '0, 3, 1, rc, fs);
            chk("sim_wr_strobe", 64'(fs), 64'd1);
            chk("sim_wr_stable", 64'(stab_cnt - s0), 64'd3);
            chk("sim_wr_ack_lat", 64'(last_cyc[1] - rc), 64'd4);
            chk("sim_wr_wdone_lat", 64'(last_cyc[4] - rc), 64'd6);
        end

        // Contention: both held, grant order D,D,D,D,S repeated.
        stall_cfg = 0; rd_lat = 1;
        for (int g = 0; g < 10; g++) begin
            if (g % 5 == 4) begin
                push(1, '0, '0);
                push(3, 32'h55550030, exp_disp_rd);
                exp_sim_rd = 32'h55550030;
            end else begin
                push(0, '0, '0);
                push(2, 32'hDDDD0020, exp_sim_rd);
                exp_disp_rd = 32'hDDDD0020;
            end
        end
        disp_addr = 16'h0020; sim_addr = 16'h0030; sim_we = 1'b0;
        disp_req = 1'b1; sim_req = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 200 && n_ack < 10; i++) begin
            @(negedge clock);
            if (disp_ack || sim_ack) n_ack++;
        end
        disp_req = 1'b0; sim_req = 1'b0;
        chk("contend_acks", 64'(n_ack), 64'd10);
        drain("contend");

        // Routing: display request arrives while a sim read is outstanding.
        stall_cfg = 0; rd_lat = 3;
        push(1, '0, '0);
        push(3, 32'hBEEF0050, exp_disp_rd);
        push(0, '0, '0);
        push(2, 32'h0DD00051, 32'hBEEF0050);
        exp_sim_rd = 32'hBEEF0050; exp_disp_rd = 32'h0DD00051;
        sim_addr = 16'h0050; sim_we = 1'b0; sim_req = 1'b1;
        wait_ack(1'b1, "route_sim", fs);
        sim_req = 1'b0;
        @(negedge clock);
        disp_addr = 16'h0051; disp_req = 1'b1;
        wait_ack(1'b0, "route_disp", fs);
        disp_req = 1'b0;
        drain("route");

        // Reset while in WAIT_RD; the late read data must be dropped.
        rd_lat = 4;
        push(1, '0, '0);
        sim_addr = 16'h0040; sim_we = 1'b0; sim_req = 1'b1;
        wait_ack(1'b1, "rst_sim", fs);
        sim_req = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_disp_rd = '0; exp_sim_rd = '0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_strobes", 64'({avm_if.avm_read, avm_if.avm_write}), 64'd0);
        repeat (5) @(negedge clock);
        chk("rst_mid_sim_rdata", 64'(sim_rdata), 64'd0);
        chk("rst_mid_busy_after", 64'(busy), 64'd0);
        drain("rst_mid");
        run_txn("post_rst_rd", 1'b1, 1'b0, 16'h0041, '0, 32'h0BAD0041, 0, 1, rc, fs);
        chk("post_rst_lat", 64'(last_cyc[3] - rc), 64'd3);

`ifdef FB_ARB_STATS_EN
        do_reset();
        run_txn("st_d0", 1'b0, 1'b0, 16'h0010, '0, 32'hAAAA5555, 2, 1, rc, fs);
        run_txn("st_d1", 1'b0, 1'b0, 16'h0020, '0, 32'hDDDD0020, 0, 1, rc, fs);
        run_txn("st_d2", 1'b0, 1'b0, 16'h0051, '0, 32'h0DD00051, 3, 1, rc, fs);
        run_txn("st_s0", 1'b1, 1'b0, 16'h0030, '0, 32'h55550030, 0, 1, rc, fs);
        run_txn("st_s1", 1'b1, 1'b0, 16'h0050, '0, 32'hBEEF0050, 0, 1, rc, fs);
        chk("stat_disp_grants", 64'(disp_grants), 64'd3);
        chk("stat_sim_grants", 64'(sim_grants), 64'd2);
        chk("stat_stall_cycles", 64'(stall_cycles), 64'd5);
`endif

        chk("final_pending", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
